// File: rtl/state_machine.sv
// Moore control FSM sequencing fetch, decode and execute of one instruction into CS_BITS.
// Define SM_MULTIPLY_EN to include the MUL_LD/MUL_LO/MUL_HI multiply path.
module state_machine (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  family_number,
    input  logic        COND,
    input  logic        L,
    input  logic        P,
    input  logic        A,
    input  logic        mem_ready,
    input  logic        IR_20,
    output logic [63:0] CS_BITS
);

    localparam int MARMUX2    = 32;
    localparam int MARMUX1    = 33;
    localparam int LD_MAR     = 34;
    localparam int LD_MWDR    = 35;
    localparam int LD_MRDR    = 36;
    localparam int LD_IR      = 37;
    localparam int IR_RD_MUX  = 42;
    localparam int GATE_MUL   = 44;
    localparam int MUL_HILO   = 45;
    localparam int LD_MUL     = 46;
    localparam int REG_GATE_C = 47;
    localparam int REG_GATE_B = 48;
    localparam int DATA_MUX   = 49;
    localparam int PC_MUX     = 50;
    localparam int RD_MUX     = 51;
    localparam int LATCH_REG  = 52;

    // Encodings are fixed so the non-multiply build leaves 6..8 as illegal codes.
    typedef enum logic [4:0] {
        IDLE       = 5'd0,
        FETCH_ADDR = 5'd1,
        FETCH_WAIT = 5'd2,
        PC_INC     = 5'd3,
        DECODE     = 5'd4,
        DP_EXEC    = 5'd5,
`ifdef SM_MULTIPLY_EN
        MUL_LD     = 5'd6,
        MUL_LO     = 5'd7,
        MUL_HI     = 5'd8,
`endif
        LS_ADDR    = 5'd9,
        LD_WAIT    = 5'd10,
        LD_WB      = 5'd11,
        ST_DATA    = 5'd12,
        ST_WAIT    = 5'd13,
        LS_BASE_WB = 5'd14,
        BR_LINK    = 5'd15,
        BR_PC      = 5'd16
    } state_e;

    state_e state_q, state_d;

`ifdef SM_MULTIPLY_EN
    logic unused_ir_20;
    assign unused_ir_20 = IR_20;
`else
    logic unused_inputs;
    assign unused_inputs = IR_20 ^ A;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:       state_d = FETCH_ADDR;
            FETCH_ADDR: state_d = FETCH_WAIT;
            FETCH_WAIT: state_d = mem_ready ? PC_INC : FETCH_WAIT;
            PC_INC:     state_d = DECODE;
            DECODE: begin
                state_d = FETCH_ADDR;
                if (COND) begin
                    case (family_number)
                        4'd0, 4'd1, 4'd2:        state_d = DP_EXEC;
`ifdef SM_MULTIPLY_EN
                        4'd3:                    state_d = MUL_LD;
`endif
                        4'd8, 4'd9, 4'd10, 4'd11: state_d = LS_ADDR;
                        4'd14:                   state_d = P ? BR_LINK : BR_PC;
                        default:                 state_d = FETCH_ADDR;
                    endcase
                end
            end
            DP_EXEC:    state_d = FETCH_ADDR;
`ifdef SM_MULTIPLY_EN
            MUL_LD:     state_d = MUL_LO;
            MUL_LO:     state_d = A ? MUL_HI : FETCH_ADDR;
            MUL_HI:     state_d = FETCH_ADDR;
`endif
            LS_ADDR:    state_d = L ? LD_WAIT : ST_DATA;
            LD_WAIT:    state_d = mem_ready ? LD_WB : LD_WAIT;
            LD_WB:      state_d = P ? FETCH_ADDR : LS_BASE_WB;
            ST_DATA:    state_d = ST_WAIT;
            ST_WAIT: begin
                state_d = ST_WAIT;
                if (mem_ready) begin
                    state_d = P ? FETCH_ADDR : LS_BASE_WB;
                end
            end
            LS_BASE_WB: state_d = FETCH_ADDR;
            BR_LINK:    state_d = BR_PC;
            BR_PC:      state_d = FETCH_ADDR;
            default:    state_d = IDLE;
        endcase
    end

    // Control word decodes from the registered state only.
    always_comb begin
        CS_BITS = '0;
        case (state_q)
            FETCH_ADDR: begin
                CS_BITS[LD_MAR]  = 1'b1;
                CS_BITS[MARMUX1] = 1'b1;
            end
            FETCH_WAIT: CS_BITS[LD_IR] = 1'b1;
            PC_INC: begin
                CS_BITS[LATCH_REG] = 1'b1;
                CS_BITS[PC_MUX]    = 1'b1;
            end
            DP_EXEC: begin
                CS_BITS[REG_GATE_B] = 1'b1;
                CS_BITS[REG_GATE_C] = 1'b1;
                CS_BITS[RD_MUX]     = 1'b1;
                CS_BITS[LATCH_REG]  = 1'b1;
            end
`ifdef SM_MULTIPLY_EN
            MUL_LD: begin
                CS_BITS[REG_GATE_B] = 1'b1;
                CS_BITS[REG_GATE_C] = 1'b1;
                CS_BITS[LD_MUL]     = 1'b1;
            end
            MUL_LO: begin
                CS_BITS[GATE_MUL]  = 1'b1;
                CS_BITS[RD_MUX]    = 1'b1;
                CS_BITS[LATCH_REG] = 1'b1;
            end
            MUL_HI: begin
                CS_BITS[MUL_HILO]  = 1'b1;
                CS_BITS[GATE_MUL]  = 1'b1;
                CS_BITS[IR_RD_MUX] = 1'b1;
                CS_BITS[LATCH_REG] = 1'b1;
            end
`endif
            LS_ADDR: begin
                CS_BITS[REG_GATE_B] = 1'b1;
                CS_BITS[LD_MAR]     = 1'b1;
                CS_BITS[MARMUX2]    = 1'b1;
            end
            LD_WAIT: CS_BITS[LD_MRDR] = 1'b1;
            LD_WB: begin
                CS_BITS[DATA_MUX]  = 1'b1;
                CS_BITS[LATCH_REG] = 1'b1;
            end
            ST_DATA: begin
                CS_BITS[REG_GATE_B] = 1'b1;
                CS_BITS[LD_MWDR]    = 1'b1;
            end
            LS_BASE_WB: begin
                CS_BITS[RD_MUX]    = 1'b1;
                CS_BITS[LATCH_REG] = 1'b1;
            end
            BR_LINK: begin
                CS_BITS[IR_RD_MUX] = 1'b1;
                CS_BITS[LATCH_REG] = 1'b1;
            end
            BR_PC: begin
                CS_BITS[PC_MUX] = 1'b1;
                CS_BITS[RD_MUX] = 1'b1;
            end
            default: CS_BITS = '0;
        endcase
    end

endmodule

// File: tb/tb_state_machine.sv
// Self-checking bench for state_machine: an instruction-level model expands each
// instruction into its expected per-cycle control words and mem_ready schedule.
module tb_state_machine;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  family_number;
    logic        COND, L, P, A, mem_ready, IR_20;
    logic [63:0] CS_BITS;

    int checks   = 0;
    int failures = 0;

    state_machine dut (
        .clk(clk), .rst(rst), .family_number(family_number), .COND(COND),
        .L(L), .P(P), .A(A), .mem_ready(mem_ready), .IR_20(IR_20), .CS_BITS(CS_BITS)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [63:0] B1    = 64'd1;
    localparam logic [63:0] E_FA  = (B1 << 34) | (B1 << 33);
    localparam logic [63:0] E_FW  = (B1 << 37);
    localparam logic [63:0] E_PI  = (B1 << 52) | (B1 << 50);
    localparam logic [63:0] E_DEC = 64'd0;
    localparam logic [63:0] E_DP  = (B1 << 48) | (B1 << 47) | (B1 << 51) | (B1 << 52);
    localparam logic [63:0] E_MLD = (B1 << 48) | (B1 << 47) | (B1 << 46);
    localparam logic [63:0] E_MLO = (B1 << 44) | (B1 << 51) | (B1 << 52);
    localparam logic [63:0] E_MHI = (B1 << 45) | (B1 << 44) | (B1 << 42) | (B1 << 52);
    localparam logic [63:0] E_LSA = (B1 << 48) | (B1 << 34) | (B1 << 32);
    localparam logic [63:0] E_LDW = (B1 << 36);
    localparam logic [63:0] E_LWB = (B1 << 49) | (B1 << 52);
    localparam logic [63:0] E_STD = (B1 << 48) | (B1 << 35);
    localparam logic [63:0] E_STW = 64'd0;
    localparam logic [63:0] E_BWB = (B1 << 51) | (B1 << 52);
    localparam logic [63:0] E_BRL = (B1 << 42) | (B1 << 52);
    localparam logic [63:0] E_BRP = (B1 << 50) | (B1 << 51);

    typedef struct {
        logic [63:0] bits;
        logic        ready;
        logic [3:0]  fam;
        logic        cond, l, p, a;
    } step_t;

    step_t q[$];
    logic [3:0] i_fam;
    logic       i_cond, i_l, i_p, i_a;

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(logic [63:0] bits, logic ready);
        step_t s;
        s.bits = bits; s.ready = ready; s.fam = i_fam;
        s.cond = i_cond; s.l = i_l; s.p = i_p; s.a = i_a;
        q.push_back(s);
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction, starting at its fetch.
    task automatic build(input logic [3:0] fam, input logic cond, input logic l,
                         input logic p, input logic a, input int fstall, input int mstall);
        i_fam = fam; i_cond = cond; i_l = l; i_p = p; i_a = a;
        push(E_FA, rnd());
        repeat (fstall) push(E_FW, 1'b0);
        push(E_FW, 1'b1);
        push(E_PI, rnd());
        push(E_DEC, rnd());
        if (!cond) return;
        case (fam)
            4'd0, 4'd1, 4'd2: push(E_DP, rnd());
`ifdef SM_MULTIPLY_EN
            4'd3: begin
                push(E_MLD, rnd());
                push(E_MLO, rnd());
                if (a) push(E_MHI, rnd());
            end
`endif
            4'd8, 4'd9, 4'd10, 4'd11: begin
                push(E_LSA, rnd());
                if (l) begin
                    repeat (mstall) push(E_LDW, 1'b0);
                    push(E_LDW, 1'b1);
                    push(E_LWB, rnd());
                end else begin
                    push(E_STD, rnd());
                    repeat (mstall) push(E_STW, 1'b0);
                    push(E_STW, 1'b1);
                end
                if (!p) push(E_BWB, rnd());
            end
            4'd14: begin
                if (p) push(E_BRL, rnd());
                push(E_BRP, rnd());
            end
            default: ;
        endcase
    endtask

    task automatic run_queue(input string name, input int max_steps);
        int n = 0;
        step_t s;
        while (q.size() > 0 && n < max_steps) begin
            s = q.pop_front();
            @(negedge clk);
            checks++;
            if (CS_BITS !== s.bits) begin
                failures++;
                $display("FAIL %s step %0d: CS_BITS=%h expected %h", name, n, CS_BITS, s.bits);
            end
            mem_ready = s.ready; family_number = s.fam; COND = s.cond;
            L = s.l; P = s.p; A = s.a; IR_20 = rnd();
            n++;
        end
        q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1; family_number = 4'd0;
        COND = 1'b1; L = 1'b0; P = 1'b0; A = 1'b0; IR_20 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (CS_BITS !== 64'd0) begin
            failures++; $display("FAIL reset_hold: CS_BITS=%h expected 0", CS_BITS);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (CS_BITS !== 64'h0000_0006_0000_0000) begin
            failures++; $display("FAIL reset_fetch_addr: CS_BITS=%h expected %h", CS_BITS, E_FA);
        end
        @(negedge clk);
        checks++;
        if (CS_BITS !== E_FW) begin
            failures++; $display("FAIL reset_fetch_wait: CS_BITS=%h expected %h", CS_BITS, E_FW);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (CS_BITS !== 64'd0) begin
            failures++; $display("FAIL async_reset: CS_BITS=%h expected 0", CS_BITS);
        end
        @(negedge clk);
        checks++;
        if (CS_BITS !== 64'd0) begin
            failures++; $display("FAIL reset_held_zero: CS_BITS=%h expected 0", CS_BITS);
        end
        rst = 1'b0;
    endtask

    task automatic test_fetch_stall();
        build(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 0);
        build(4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        run_queue("fetch_stall", 1000);
    endtask

    task automatic test_cond_fail();
        build(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        build(4'd14, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0);
        build(4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        run_queue("cond_fail", 1000);
    endtask

    task automatic test_load_store();
        build(4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 0, 2);
        build(4'd9, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
        build(4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1, 2);
        build(4'd11, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1);
        build(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        run_queue("load_store", 1000);
    endtask

    task automatic test_branch();
        build(4'd14, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
        build(4'd14, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        build(4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        run_queue("branch", 1000);
    endtask

    task automatic test_multiply();
        build(4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0);
        build(4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        build(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        run_queue("multiply", 1000);
    endtask

    task automatic test_reset_mid_wait();
        build(4'd8, 1'b1, 1'b1, 1'b1, 1'b0, 0, 10);
        run_queue("reset_mid_wait_entry", 7);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (CS_BITS !== 64'd0) begin
            failures++; $display("FAIL reset_mid_wait_async: CS_BITS=%h expected 0", CS_BITS);
        end
        mem_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (CS_BITS !== 64'd0) begin
                failures++; $display("FAIL reset_mid_wait_hold: CS_BITS=%h expected 0", CS_BITS);
            end
        end
        rst = 1'b0;
        build(4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        run_queue("reset_mid_wait_resume", 1000);
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            build(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0), rnd(), rnd(), rnd(),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        run_queue("random", 100000);
    endtask

    // Cycles from one FETCH_ADDR to the next with mem_ready held high.
    task automatic measure(input string name, input logic [3:0] fam, input logic p, input int expect_cycles);
        int n = 0;
        family_number = fam; COND = 1'b1; P = p; L = 1'b0; A = 1'b0; mem_ready = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (CS_BITS !== E_FA && n < 20);
        checks++;
        if (n !== expect_cycles) begin
            failures++; $display("FAIL %s: cycles=%0d expected %0d", name, n, expect_cycles);
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        mem_ready = 1'b1;
        checks++;
        if (CS_BITS !== E_FA) begin
            failures++; $display("FAIL latency_start: CS_BITS=%h expected %h", CS_BITS, E_FA);
        end
        measure("latency_dp", 4'd0, 1'b0, 5);
        measure("latency_bl", 4'd14, 1'b1, 6);
        measure("latency_b", 4'd14, 1'b0, 5);
    endtask

    initial begin
        test_reset();
        test_fetch_stall();
        test_cond_fail();
        test_load_store();
        test_branch();
        test_multiply();
        test_reset_mid_wait();
        test_random();
        test_latency();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/state_machine.md
STATE_MACHINE -- requirements
Module: state_machine

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes occur on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 The block SHALL have port family_number, input, 4 bits: decoded instruction family (0 DPI, 1 DPIS, 2 DPRS, 3 MUL, 8 LSIO, 9 LSRO, 10 LSHSBCO, 11 LSHSBSO, 14 B/BL; all other codes are "other").
REQ-004 The block SHALL have port COND, input, 1 bit: the current instruction's condition passes.
REQ-005 The block SHALL have port L, input, 1 bit: IR[20], load (1) or store (0).
REQ-006 The block SHALL have port P, input, 1 bit: IR[24], pre-index for load/store and the link bit for branch.
REQ-007 The block SHALL have port A, input, 1 bit: IR[21], multiply high-word writeback request.
REQ-008 The block SHALL have port mem_ready, input, 1 bit: memory access is complete this cycle.
REQ-009 The block SHALL have port IR_20, input, 1 bit: reserved; it SHALL be ignored.
REQ-010 The block SHALL have port CS_BITS, output, 64 bits: the control word.
REQ-011 CS_BITS bit meanings SHALL be: 32 MARMUX2 (address from ALU), 33 MARMUX1 (address from PC), 34 LD_MAR, 35 LD_MWDR, 36 LD_MRDR, 37 LD_IR, 42 IR_RD_MUX (select R14), 44 GATE_MUL, 45 MUL_HiLo, 46 LD_MUL, 47 REG_GATE_C, 48 REG_GATE_B, 49 DATA_MUX, 50 PC_MUX, 51 RD_MUX, 52 LATCH_REG; all other bits SHALL be 0.

Function
REQ-012 The block SHALL be a Moore FSM: CS_BITS SHALL be a pure function of the registered state, with no input-to-output combinational path.
REQ-013 The states and their asserted CS_BITS bits SHALL be: IDLE (none), FETCH_ADDR (34, 33), FETCH_WAIT (37), PC_INC (52, 50), DECODE (none), DP_EXEC (48, 47, 51, 52), MUL_LD (48, 47, 46), MUL_LO (44, 51, 52), MUL_HI (45, 44, 42, 52), LS_ADDR (48, 34, 32), LD_WAIT (36), LD_WB (49, 52), ST_DATA (48, 35), ST_WAIT (none), LS_BASE_WB (51, 52), BR_LINK (42, 52), BR_PC (50, 51).
REQ-014 Transitions from the fetch and decode states SHALL be: IDLE -> FETCH_ADDR; FETCH_ADDR -> FETCH_WAIT; FETCH_WAIT holds while mem_ready=0 and goes -> PC_INC when mem_ready=1; PC_INC -> DECODE.
REQ-015 DECODE SHALL go -> FETCH_ADDR when COND=0, whatever the family.
REQ-016 When COND=1, DECODE SHALL branch on family_number: families 0/1/2 -> DP_EXEC; 3 -> MUL_LD; 8/9/10/11 -> LS_ADDR; 14 -> BR_LINK if P=1, else BR_PC; any other family -> FETCH_ADDR (treated as a no-op).
REQ-017 The execution paths SHALL be:
- DP_EXEC -> FETCH_ADDR.
- MUL_LD -> MUL_LO. MUL_LO -> MUL_HI if A=1, else FETCH_ADDR. MUL_HI -> FETCH_ADDR.
- LS_ADDR -> LD_WAIT if L=1, else ST_DATA.
- LD_WAIT holds until mem_ready=1, then -> LD_WB.
- ST_DATA -> ST_WAIT. ST_WAIT holds until mem_ready=1, then -> LS_BASE_WB if P=0, else FETCH_ADDR.
- LD_WB -> LS_BASE_WB if P=0, else FETCH_ADDR. LS_BASE_WB -> FETCH_ADDR.
- BR_LINK -> BR_PC. BR_PC -> FETCH_ADDR.
REQ-018 An unreachable or illegal state encoding SHALL go -> IDLE on the next clock.
REQ-019 Wait states SHALL hold indefinitely while mem_ready=0, with no timeout.
REQ-020 mem_ready SHALL be ignored in all non-wait states.
REQ-021 With mem_ready held at 1, DP and B (P=0) instructions SHALL take 5 cycles from FETCH_ADDR to the next FETCH_ADDR; BL SHALL take 6.

Reset
REQ-022 Asserting rst SHALL force the state to IDLE immediately, without waiting for a clock edge.
REQ-023 While rst is asserted, CS_BITS SHALL be all zeros.
REQ-024 A reset asserted mid-instruction, including inside a wait state, SHALL abort the instruction, with no further control bits asserted.
REQ-025 After rst deasserts, the first rising clock edge SHALL move the state IDLE -> FETCH_ADDR.

Configuration
REQ-026 The macro SM_MULTIPLY_EN SHALL control multiply support.
REQ-027 When SM_MULTIPLY_EN is defined, family 3 SHALL follow the MUL_LD/MUL_LO/MUL_HI path.
REQ-028 When SM_MULTIPLY_EN is undefined, the MUL states SHALL be absent, family 3 SHALL be treated as "other" (DECODE -> FETCH_ADDR), and CS_BITS bits 44, 45 and 46 SHALL never assert.

Verification
REQ-029 Reset and fetch: rst=1 then released, mem_ready=1 -> CS_BITS=0 during reset, then 0x0000_0006_0000_0000 (bits 34, 33) on the 1st cycle, then bit 37 only on the 2nd.
REQ-030 Fetch stall: mem_ready=0 for 3 cycles in FETCH_WAIT -> bit 37 stays asserted for 4 cycles, and PC_INC (bits 52, 50) follows exactly once.
REQ-031 Condition fail: COND=0, family 0 at DECODE -> next state FETCH_ADDR, and DP_EXEC bits never appear.
REQ-032 Load post-index: family 8, L=1, P=0, mem_ready low for 2 cycles -> sequence LS_ADDR, LD_WAIT x3, LD_WB (bits 49, 52), LS_BASE_WB, FETCH_ADDR.
REQ-033 Branch-with-link: family 14, P=1 -> BR_LINK (bits 42, 52), then BR_PC (bits 50, 51), then FETCH_ADDR.
REQ-034 Multiply: family 3, A=1, with and without SM_MULTIPLY_EN -> MUL_LD, MUL_LO, MUL_HI when defined; DECODE -> FETCH_ADDR with bits 44-46 never set when undefined.
